// File: rtl/dm_wait_ctrl_if.sv
// Request/response bundle between the datapath and the wait-state data memory.
interface dm_wait_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output MemRead, MemWrite, addr, din, be,
                  input  dout, busy, done, err);
  modport slave  (input  MemRead, MemWrite, addr, din, be,
                  output dout, busy, done, err);
endinterface

// File: rtl/dm_wait_ctrl.sv
// Word-organised data memory with byte enables and programmable wait states.
// Optional DM_CLEAR_ON_RST_EN zeroes the array word-by-word after reset.
module dm_wait_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end
endmodule

module dm_wait_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  dm_wait_ctrl_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

`ifdef DM_CLEAR_ON_RST_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
`endif

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [IDX_W-1:0]  a_idx, lane_idx;
  logic [DATA_W-1:0] a_din;
  logic [NB-1:0]     a_be;
  logic              a_wr, a_err;
  logic              req, req_err, mis, oor, lat, acc, clr;
  logic              busy_q, done_q, err_q;
  logic [NB-1:0][7:0] rdata;

  assign req     = bus.MemRead | bus.MemWrite;
  assign mis     = (bus.addr & ADDR_W'(NB - 1)) != '0;
  assign oor     = {1'b0, bus.addr} >= (ADDR_W + 1)'(DEPTH * NB);
  assign req_err = mis | oor | (bus.MemRead & bus.MemWrite);

`ifdef DM_CLEAR_ON_RST_EN
  // Extra MSB marks "all DEPTH words written"; the FSM leaves CLEAR one edge later.
  logic [IDX_W:0] clr_idx;
  assign clr      = (state == S_CLEAR) && !clr_idx[IDX_W] && !rst;
  assign lane_idx = clr ? clr_idx[IDX_W-1:0] : a_idx;

  always_ff @(posedge clk) begin
    if (rst)      clr_idx <= '0;
    else if (clr) clr_idx <= clr_idx + 1'b1;
  end
`else
  assign clr      = 1'b0;
  assign lane_idx = a_idx;
`endif

  // RESP also accepts, so a new request lands on the edge that retires the old one.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lat     = 1'b0;
    acc     = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        state_n = S_IDLE;
        if (req) begin
          lat     = 1'b1;
          cnt_n   = 4'(WAIT_CYC);
          state_n = req_err ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          acc     = 1'b1;
          state_n = S_RESP;
        end
      end
`ifdef DM_CLEAR_ON_RST_EN
      S_CLEAR: if (clr_idx[IDX_W]) state_n = S_IDLE;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DM_CLEAR_ON_RST_EN
      state <= S_CLEAR;
`else
      state <= S_IDLE;
`endif
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy_q <= state_n != S_IDLE;
      done_q <= state_n == S_RESP;
      err_q  <= (state_n == S_RESP) && (lat ? req_err : a_err);
    end
  end

  always_ff @(posedge clk) begin
    if (lat) begin
      a_idx <= bus.addr[OFS+IDX_W-1:OFS];
      a_din <= bus.din;
      a_be  <= bus.be;
      a_wr  <= bus.MemWrite;
      a_err <= req_err;
    end
  end

  // rst gates the access strobes so a reset on the access edge drops the write.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    dm_wait_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (clr | (acc & a_wr & a_be[i] & ~rst)),
      .re    (acc & ~a_wr & ~rst),
      .idx   (lane_idx),
      .wdata (clr ? 8'h00 : a_din[8*i +: 8]),
      .rdata (rdata[i])
    );
  end

  assign bus.dout = rdata;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule
